// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: opcodes, funct codes,
// datapath mux selects and state codes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  typedef logic [3:0] state_t;

  localparam state_t S_FETCH   = 4'd0;
  localparam state_t S_DECODE  = 4'd1;
  localparam state_t S_MEMADR  = 4'd2;
  localparam state_t S_MEMRD   = 4'd3;
  localparam state_t S_MEMWB   = 4'd4;
  localparam state_t S_MEMWR   = 4'd5;
  localparam state_t S_EXEC    = 4'd6;
  localparam state_t S_RWB     = 4'd7;
  localparam state_t S_ADDI_EX = 4'd8;
  localparam state_t S_ADDI_WB = 4'd9;
  localparam state_t S_BRANCH  = 4'd10;
  localparam state_t S_JUMP    = 4'd11;
  localparam state_t S_JAL     = 4'd12;
  localparam state_t S_JR      = 4'd13;

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS core. Moore outputs from the state
// register, with mem_ready gating in the memory-access states.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       JumpAndLink,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done
);

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    JumpAndLink = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    instr_done  = 1'b0;

    case (r_state)
      S_FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        PCSource = PCSRC_ALU;
        IRWrite  = mem_ready;
        PCWrite  = mem_ready;
        if (mem_ready) begin
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculatively form the branch target into ALUOut.
        ALUSrcB = SRCB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = (funct == FN_JR) ? S_JR : S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDI_EX;
          OP_J:         w_next = S_JUMP;
          OP_JAL:       w_next = S_JAL;
          default: begin
            instr_done = 1'b1;
            w_next     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        w_next  = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          w_next = S_MEMWB;
        end
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWR: begin
        // Write request held across stalls; memory commits on the ready cycle.
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) begin
          w_next = S_FETCH;
        end
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_B;
        ALUOp   = ALUOP_FUNCT;
        w_next  = S_RWB;
      end
      S_RWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        w_next  = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_B;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        instr_done  = 1'b1;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = PCSRC_JUMP;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      S_JAL: begin
        // Link value is the PC already incremented during FETCH.
        PCWrite     = 1'b1;
        PCSource    = PCSRC_JUMP;
        RegWrite    = 1'b1;
        JumpAndLink = 1'b1;
        instr_done  = 1'b1;
        w_next      = S_FETCH;
      end
      S_JR: begin
        PCWrite    = 1'b1;
        PCSource   = PCSRC_REG;
        instr_done = 1'b1;
        w_next     = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase

    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      MemWrite    = 1'b0;
      RegWrite    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction expected output
// sequences built from the instruction class and wait counts.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, JumpAndLink, RegWrite, ALUSrcA, instr_done;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .MemtoReg   (MemtoReg),
    .RegDst     (RegDst),
    .JumpAndLink(JumpAndLink),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .PCSource   (PCSource),
    .instr_done (instr_done)
  );

  always #5 clk = ~clk;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_JR = 3, C_BEQ = 4;
  localparam int C_ADDI = 5, C_J = 6, C_JAL = 7, C_UNK = 8;
  // PCWrite, PCWriteCond, MemWrite, IRWrite, RegWrite bit positions
  localparam logic [18:0] WMASK = 19'h66200;

  wire [18:0] w_obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                       RegDst, JumpAndLink, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                       instr_done};

  int n_cmp = 0;
  int n_err = 0;

  logic [18:0] q_exp[$];
  logic        q_rdy[$];
  logic        q_opv[$];

  int         o_done, o_mw, o_jal, o_wr_late;
  logic       o_last_done;
  logic [1:0] o_ps;

  function automatic logic [18:0] ov(input logic pcw, input logic pcwc, input logic iord,
                                     input logic mr, input logic mw, input logic irw,
                                     input logic m2r, input logic rdst, input logic jl,
                                     input logic rw, input logic sa, input logic [1:0] sb,
                                     input logic [2:0] op, input logic [1:0] ps,
                                     input logic dn);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, jl, rw, sa, sb, op, ps, dn};
  endfunction

  function automatic logic [18:0] ev_fetch(input logic r);
    return ov(r, 0, 0, 1, 0, r, 0, 0, 0, 0, 0, 2'b01, 3'b000, 2'b00, 0);
  endfunction

  function automatic logic [5:0] opc_of(input int cls);
    logic [5:0] o;
    case (cls)
      C_LW:   o = 6'b100011;
      C_SW:   o = 6'b101011;
      C_R:    o = 6'b000000;
      C_JR:   o = 6'b000000;
      C_BEQ:  o = 6'b000100;
      C_ADDI: o = 6'b001000;
      C_J:    o = 6'b000010;
      C_JAL:  o = 6'b000011;
      default: begin
        do o = 6'($urandom);
        while (o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                         6'b000010, 6'b000011});
      end
    endcase
    return o;
  endfunction

  function automatic logic [5:0] fn_of(input int cls);
    logic [5:0] f;
    if (cls == C_JR) return 6'b001000;
    do f = 6'($urandom); while (cls == C_R && f == 6'b001000);
    return f;
  endfunction

  task automatic add(input logic [18:0] e, input logic r, input logic v);
    q_exp.push_back(e);
    q_rdy.push_back(r);
    q_opv.push_back(v);
  endtask

  // Expected cycle-by-cycle outputs of one instruction.
  task automatic plan(input int cls, input int fw, input int mw);
    q_exp.delete(); q_rdy.delete(); q_opv.delete();
    for (int i = 0; i < fw; i++) add(ev_fetch(0), 1'b0, 1'b0);
    add(ev_fetch(1), 1'b1, 1'b0);
    add(ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b000, 2'b00, cls == C_UNK),
        1'($urandom), 1'b1);
    case (cls)
      C_LW: begin
        add(ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 2'b00, 0), 1'($urandom), 1'b1);
        for (int i = 0; i <= mw; i++)
          add(ov(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0), i == mw, 1'b0);
        add(ov(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 3'b000, 2'b00, 1), 1'($urandom), 1'b0);
      end
      C_SW: begin
        add(ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 2'b00, 0), 1'($urandom), 1'b1);
        for (int i = 0; i <= mw; i++)
          add(ov(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, i == mw), i == mw, 1'b0);
      end
      C_R: begin
        add(ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 2'b00, 0), 1'($urandom), 1'b0);
        add(ov(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000, 2'b00, 1), 1'($urandom), 1'b0);
      end
      C_ADDI: begin
        add(ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 2'b00, 0), 1'($urandom), 1'b0);
        add(ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 2'b00, 1), 1'($urandom), 1'b0);
      end
      C_BEQ: add(ov(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 2'b01, 1), 1'($urandom), 1'b0);
      C_J:   add(ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 1), 1'($urandom), 1'b0);
      C_JAL: add(ov(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000, 2'b10, 1), 1'($urandom), 1'b0);
      C_JR:  add(ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b11, 1), 1'($urandom), 1'b0);
      default: ;
    endcase
  endtask

  // Runs one instruction from FETCH; entered and left at negedge+1.
  task automatic exec_instr(input int cls, input int fw, input int mw);
    logic [5:0] opc, fn;
    opc = opc_of(cls);
    fn  = fn_of(cls);
    plan(cls, fw, mw);
    o_done = 0; o_mw = 0; o_jal = 0; o_wr_late = 0; o_last_done = 1'b0; o_ps = 2'b00;
    for (int i = 0; i < q_exp.size(); i++) begin
      @(negedge clk);
      mem_ready = q_rdy[i];
      if (q_opv[i]) begin
        opcode = opc;
        funct  = fn;
      end else begin
        opcode = 6'($urandom);
        funct  = 6'($urandom);
      end
      #1;
      n_cmp++;
      if (w_obs !== q_exp[i]) begin
        n_err++;
        $display("FAIL instr cls=%0d cyc=%0d: outputs got %b want %b", cls, i, w_obs,
                 q_exp[i]);
      end
      o_done      += int'(instr_done);
      o_mw        += int'(MemWrite);
      o_jal       += int'(JumpAndLink);
      o_last_done  = instr_done;
      if (instr_done) o_ps = PCSource;
      if (i > fw && (PCWrite || MemWrite || RegWrite)) o_wr_late++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'b000000; funct = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ((w_obs & WMASK) !== 19'h0) begin
        n_err++;
        $display("FAIL reset_writes cyc=%0d: got %b want 0", i, w_obs & WMASK);
      end
    end
    @(negedge clk); reset = 1'b0; #1;
    n_cmp++;
    if (w_obs !== ev_fetch(1)) begin
      n_err++;
      $display("FAIL reset_first_fetch: got %b want %b", w_obs, ev_fetch(1));
    end
    // Finish that fetch as an unknown opcode so the FSM is back in FETCH.
    @(negedge clk); opcode = 6'b111111; #1;
    n_cmp++;
    if (w_obs !== ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b000, 2'b00, 1)) begin
      n_err++;
      $display("FAIL reset_nop_decode: got %b", w_obs);
    end
  endtask

  task automatic test_lw;
    exec_instr(C_LW, 0, 0);
    n_cmp++;
    if (o_done !== 1 || o_last_done !== 1'b1) begin
      n_err++;
      $display("FAIL lw_done: got count %0d last %b want 1 1", o_done, o_last_done);
    end
  endtask

  task automatic test_sw_stall;
    exec_instr(C_SW, 0, 2);
    n_cmp++;
    if (o_mw !== 3) begin
      n_err++;
      $display("FAIL sw_memwrite_cycles: got %0d want 3", o_mw);
    end
    n_cmp++;
    if (o_done !== 1 || o_last_done !== 1'b1) begin
      n_err++;
      $display("FAIL sw_done: got count %0d last %b want 1 1", o_done, o_last_done);
    end
  endtask

  task automatic test_branch_jumps;
    int         cls [3] = '{C_BEQ, C_JAL, C_JR};
    logic [1:0] ps  [3] = '{2'b01, 2'b10, 2'b11};
    int         jl  [3] = '{0, 1, 0};
    for (int k = 0; k < 3; k++) begin
      exec_instr(cls[k], 0, 0);
      n_cmp++;
      if (o_ps !== ps[k] || o_jal !== jl[k]) begin
        n_err++;
        $display("FAIL branch_jump k=%0d: PCSource %b jal %0d want %b %0d", k, o_ps, o_jal,
                 ps[k], jl[k]);
      end
    end
  endtask

  task automatic test_unknown;
    exec_instr(C_UNK, 0, 0);
    n_cmp++;
    if (o_wr_late !== 0 || o_last_done !== 1'b1) begin
      n_err++;
      $display("FAIL unknown_nop: late writes %0d done %b want 0 1", o_wr_late, o_last_done);
    end
  endtask

  task automatic abort_with_reset(input string name);
    @(negedge clk); reset = 1'b1; mem_ready = 1'b0; #1;
    n_cmp++;
    if ((w_obs & WMASK) !== 19'h0) begin
      n_err++;
      $display("FAIL %s_writes: got %b want 0", name, w_obs & WMASK);
    end
    @(negedge clk); reset = 1'b0; mem_ready = 1'b0; #1;
    n_cmp++;
    if (w_obs !== ev_fetch(0)) begin
      n_err++;
      $display("FAIL %s_refetch: got %b want %b", name, w_obs, ev_fetch(0));
    end
  endtask

  task automatic test_reset_mid;
    // R-type: FETCH, DECODE, then reset in EXEC.
    @(negedge clk); mem_ready = 1'b1; #1;
    @(negedge clk); opcode = 6'b000000; funct = 6'b100000; #1;
    abort_with_reset("reset_exec");
    // lw stalled in MEMRD, then reset.
    @(negedge clk); mem_ready = 1'b1; #1;
    @(negedge clk); opcode = 6'b100011; #1;
    @(negedge clk); #1;
    @(negedge clk); mem_ready = 1'b0; #1;
    abort_with_reset("reset_stall");
  endtask

  task automatic test_random;
    logic prev_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      int cls = int'($urandom_range(0, 8));
      exec_instr(cls, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      n_cmp++;
      if (o_done !== 1) begin
        n_err++;
        $display("FAIL random_done n=%0d: got %0d pulses want 1", n, o_done);
      end
      prev_done = o_last_done;
    end
    n_cmp++;
    if (prev_done !== 1'b1) begin
      n_err++;
      $display("FAIL random_last_done: got %b want 1", prev_done);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_branch_jumps();
    test_unknown();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle variant of the MIPS core. In this variant one unified memory, one ALU and one register file are shared across several clock cycles per instruction. The block decodes the opcode and funct fields once they are latched in the instruction register. It then issues per-cycle enables and mux selects to the PC, IR, memory, ALU, register file and PC-source mux. Memory accesses use a ready handshake, so slow memory stalls the sequence.

## Interface
Parameters:
- none; all encodings come from `mips_ctrl_pkg`.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high
- `opcode`  in  6  IR[31:26]
- `funct`  in  6  IR[5:0]; used only to detect `jr` (000000/001000)
- `mem_ready`  in  1  memory has completed the current read/write this cycle
- `PCWrite`  out  1  unconditional PC load
- `PCWriteCond`  out  1  PC load qualified by ALU zero (beq)
- `IorD`  out  1  memory address: 0 = PC, 1 = ALUOut
- `MemRead`  out  1  memory read request
- `MemWrite`  out  1  memory write request
- `IRWrite`  out  1  IR load
- `MemtoReg`  out  1  RF write data: 0 = ALUOut, 1 = MDR
- `RegDst`  out  1  RF write reg: 0 = rt, 1 = rd
- `JumpAndLink`  out  1  forces write reg 31 and write data PC
- `RegWrite`  out  1  RF write enable
- `ALUSrcA`  out  1  0 = PC, 1 = A
- `ALUSrcB`  out  2  00 = B, 01 = 4, 10 = sign-ext, 11 = sign-ext<<2
- `ALUOp`  out  3  000 add, 001 sub, 010 funct-decoded (existing ALU control encoding)
- `PCSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A (jr)
- `instr_done`  out  1  one-cycle pulse in the final cycle of each instruction

## Operation
States and required outputs (signals not listed are 0):
- FETCH: MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00. IRWrite and PCWrite are asserted only when mem_ready=1; the FSM stays in FETCH while mem_ready=0.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000 (branch target into ALUOut). Next state by opcode:
  - lw/sw (100011/101011) → MEMADR
  - R-type with funct≠001000 → EXEC
  - R-type with funct=001000 → JR
  - beq 000100 → BRANCH
  - addi 001000 → ADDI_EX
  - j 000010 → JUMP
  - jal 000011 → JAL
  - any other opcode → FETCH, with instr_done (executed as a NOP)
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead, IorD=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: RegWrite, MemtoReg=1, RegDst=0, instr_done. Next state FETCH.
- MEMWR: MemWrite, IorD=1. Hold until mem_ready; then instr_done and go to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010. Next state RWB.
- RWB: RegWrite, RegDst=1, MemtoReg=0, instr_done. Next state FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Next state ADDI_WB.
- ADDI_WB: RegWrite, RegDst=0, MemtoReg=0, instr_done. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond, PCSource=01, instr_done. Next state FETCH.
- JUMP: PCWrite, PCSource=10, instr_done. Next state FETCH.
- JAL: PCWrite, PCSource=10, RegWrite, JumpAndLink, instr_done. Next state FETCH. The link value is the PC already incremented in FETCH.
- JR: PCWrite, PCSource=11, instr_done. Next state FETCH.

## Timing
- Moore machine: outputs decode from the registered state only, except for the mem_ready gating in FETCH, MEMRD and MEMWR.
- Reset: while `reset`=1, every write-class output (PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite) is forced to 0. The state becomes FETCH on the next edge. Reset wins over every other transition, including reset asserted mid-instruction and reset asserted while stalled on mem_ready.
- Cycles per instruction with zero wait: R 4, addi 4, lw 5, sw 4, beq 3, j/jal/jr 3, unknown 2. Each wait cycle in FETCH, MEMRD or MEMWR adds 1.
- With MemWrite held during stall cycles, memory must accept the write only on the cycle where mem_ready=1.
- `opcode`/`funct` are sampled only in DECODE and MEMADR. Changes in any other state are ignored.
- instr_done must never pulse in two consecutive cycles.

## Structure
- `mips_ctrl_pkg` holds:
  - the opcode and funct constants;
  - the ALUOp, ALUSrcB and PCSource encodings;
  - the state enum, 4-bit binary encoded.
- Single module with two processes: a state register and a combinational next-state/output decode. No sub-module.

## Test plan
- Reset for 3 cycles, mem_ready=1 → all write enables 0 during reset; in the first cycle after reset, state=FETCH with IRWrite=1 and PCWrite=1.
- lw (opcode 100011), mem_ready=1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB; instr_done in cycle 5 only; MemtoReg=1 and RegWrite=1 in MEMWB.
- sw with mem_ready low for 2 cycles in MEMWR → MemWrite high for 3 cycles, instr_done only on the ready cycle, 6 cycles total.
- beq, then jal, then jr (000000/001000) → 3 cycles each; PCSource sequence 01, 10, 11; JumpAndLink=1 only in JAL.
- Opcode 111111 → 2 cycles with no RegWrite/MemWrite/PCWrite outside FETCH; instr_done in DECODE.
- Reset asserted in EXEC of an R-type instruction → no RegWrite occurs; FETCH on the following cycle.
